pipe_output_collector: RTL and testbench

PIPE_OUTPUT_COLLECTOR -- requirements
Module: pipe_output_collector

---
 rtl/pipe_output_collector.sv | 70 +++++++
 tb/tb_pipe_output_collector.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_output_collector.sv
// pipe_output_collector: credit-based result collector for a fixed-latency, non-stalling pipeline.
// Optional assertions: define PIPE_OUTPUT_COLLECTOR_ASSERT_EN.
module pipe_output_collector #(
    parameter int IN_W    = 1,
    parameter int OUT_W   = 1,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    output logic [IN_W-1:0]          pipe_in,
    input  logic [OUT_W-1:0]         pipe_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   credits
);
    localparam int AW = $clog2(DEPTH);

    logic [LATENCY-1:0] sr;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wp, rp;
    logic [AW:0]        cnt;
    logic               issue, pop, wr;

    assign in_ready  = credits != '0;
    assign issue     = in_valid && in_ready;
    assign out_valid = cnt != '0;
    assign pop       = out_valid && out_ready;
    assign wr        = sr[LATENCY-1];
    assign pipe_in   = in_data;
    assign out_data  = out_valid ? mem[rp] : '0;

    // Track in-flight issues, advance FIFO pointers/occupancy and credit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            credits <= (AW+1)'(DEPTH);
        end else begin
            sr      <= LATENCY'({sr, issue});
            wp      <= wr ? wp + AW'(1) : wp;
            rp      <= pop ? rp + AW'(1) : rp;
            cnt     <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
            credits <= credits + (AW+1)'(pop) - (AW+1)'(issue);
        end
    end

    // Capture the pipeline result when its issue reaches the last stage.
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= pipe_out;
    end

`ifdef PIPE_OUTPUT_COLLECTOR_ASSERT_EN
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr && !pop && cnt == (AW+1)'(DEPTH)))
        else $fatal(1, "pipe_output_collector: FIFO write when full");
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && cnt == '0))
        else $fatal(1, "pipe_output_collector: pop when empty");
    a_credit_range: assert property (@(posedge clk) disable iff (rst)
        credits <= (AW+1)'(DEPTH))
        else $fatal(1, "pipe_output_collector: credits exceed DEPTH");
`endif
endmodule

// File: tb/tb_pipe_output_collector.sv
// tb_pipe_output_collector: directed and random checks against a queue-based model of the collector.
module tb_pipe_output_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] pipe_in;
    logic [7:0] pipe_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] credits;
    logic [7:0] p1, p2;
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;
    int         edge_n = 0;

    typedef struct {
        logic [7:0] d;
        int         due;
    } fl_t;
    fl_t        inf[$];
    logic [7:0] st[$];

    always #5 clk = ~clk;

    pipe_output_collector #(.IN_W(8), .OUT_W(8), .LATENCY(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_in(pipe_in), .pipe_out(pipe_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .credits(credits)
    );

    // Two-stage identity pipeline.
    always @(posedge clk) begin
        p1 <= pipe_in;
        p2 <= p1;
    end
    assign pipe_out = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: issued items wait two edges in flight, then join the stored queue.
    always @(posedge clk) begin
        if (rst) begin
            inf.delete();
            st.delete();
        end else begin
            if (in_valid && inf.size() + st.size() < 4) inf.push_back('{in_data, edge_n + 2});
            if (out_ready && st.size() > 0) void'(st.pop_front());
            while (inf.size() > 0 && inf[0].due == edge_n) begin
                st.push_back(inf[0].d);
                void'(inf.pop_front());
            end
        end
        edge_n <= edge_n + 1;
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(out_valid), 32'(st.size() > 0));
            chk("m_data", 32'(out_data), st.size() > 0 ? 32'(st[0]) : 32'd0);
            chk("m_credits", 32'(credits), 32'(4 - inf.size() - st.size()));
            chk("m_ready", 32'(in_ready), 32'(inf.size() + st.size() < 4));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] nd;
        bit acc;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_credits", 32'(credits), 4);

        // Single transaction latency.
        in_valid = 1'b1; in_data = 8'h5a; out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            in_valid = 1'b0;
            chk("A_credits", 32'(credits), c < 4 ? 3 : 4);
            chk("A_valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) chk("A_data", 32'(out_data), 32'h5a);
        end

        // Back-pressure: only four accepted, then drained in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            chk("B_ready", 32'(in_ready), 32'(i <= 4));
            tick();
        end
        in_valid = 1'b0;
        chk("B_full_credits", 32'(credits), 0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("B_valid", 32'(out_valid), 1);
            chk("B_data", 32'(out_data), 32'(k));
            tick();
        end
        chk("B_empty", 32'(out_valid), 0);
        chk("B_credits", 32'(credits), 4);

        // Full FIFO with simultaneous issue and pop every cycle.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1;
        nd = 8'd5;
        for (int k = 0; k < 16; k++) begin
            chk("C_valid", 32'(out_valid), 1);
            chk("C_data", 32'(out_data), 32'(k + 1));
            if (k >= 1) chk("C_credits", 32'(credits), 1);
            in_data = nd;
            acc = in_ready;
            tick();
            if (acc) nd++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("C_drained", 32'(credits), 4);

        // Reset with transactions in flight.
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        rst = 1'b1; in_data = 8'h33;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("D_credits", 32'(credits), 4);
        for (int c = 3; c <= 8; c++) begin
            chk("D_valid", 32'(out_valid), 0);
            tick();
        end

        // Random traffic.
        for (int k = 0; k < 10000; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("E_credits", 32'(credits), 4);
        chk("E_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
